// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage constants.
// Holds the ctrl-vector field layout, the per-stage widths, the bubble
// encoding loaded on flush, and the skid-buffer state encoding.
package pipe_pkg;
  localparam int RF_WE_O    = 0;
  localparam int RF_WE_W    = 1;
  localparam int RF_WSEL_O  = 1;
  localparam int RF_WSEL_W  = 2;
  localparam int RAM_WE_O   = 3;
  localparam int RAM_WE_W   = 1;
  localparam int RAM_RSEL_O = 4;
  localparam int RAM_RSEL_W = 1;
  localparam int NPC_OP_O   = 5;
  localparam int NPC_OP_W   = 1;
  localparam int NPC_SEL_O  = 6;
  localparam int NPC_SEL_W  = 1;
  localparam int FLAG_O     = 7;
  localparam int FLAG_W     = 1;
  localparam int CTRL_W_ALL = 8;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_DATA_W  = 128;
  localparam int EX_MEM_DATA_W = 96;
  localparam int MEM_WB_DATA_W = 64;
  localparam int IF_ID_CTRL_W  = CTRL_W_ALL;
  localparam int ID_EX_CTRL_W  = CTRL_W_ALL;
  localparam int EX_MEM_CTRL_W = CTRL_W_ALL;
  localparam int MEM_WB_CTRL_W = CTRL_W_ALL;
  localparam logic [CTRL_W_ALL-1:0] CTRL_BUBBLE = '0;
  // Encoded so the state value is directly the number of held entries.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry skid buffer with a registered in_ready.
// Ports: clk, rst (async active-low), flush, stall, in_valid/in_ready/in_data/in_ctrl
// upstream, out_valid/out_ready/out_data/out_ctrl downstream, occupancy (0..2).
// Main entry m always drives out_*; s only catches the entry that arrives
// while m is blocked, so in_ready never depends on out_ready in the same cycle.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_FLUSH = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  skid_state_t state, state_nx;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic rdy, in_xfer, out_xfer, load_m, load_s, pop_s;
  assign in_ready  = rdy;
  assign out_valid = (state != EMPTY) & !stall;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = state;
  assign in_xfer   = in_valid & rdy;
  assign out_xfer  = out_valid & out_ready;
  assign load_m    = in_xfer & ((state == EMPTY) | ((state == ONE) & out_xfer));
  assign load_s    = in_xfer & (state == ONE) & !out_xfer;
  assign pop_s     = out_xfer & (state == FULL);
  always_comb begin
    state_nx = state;
    if (flush) state_nx = EMPTY;
    else
      case (state)
        EMPTY:   state_nx = in_xfer ? ONE : EMPTY;
        ONE:     state_nx = (out_xfer & !in_xfer) ? EMPTY : (in_xfer & !out_xfer) ? FULL : ONE;
        FULL:    state_nx = out_xfer ? ONE : FULL;
        default: state_nx = EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      rdy   <= 1'b0;
    end else begin
      state <= state_nx;
      rdy   <= state_nx != FULL;
    end
  end
  // Payload survives a flush; only ctrl is overwritten with the bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= '0;
      s_data <= '0;
      m_ctrl <= CTRL_FLUSH;
      s_ctrl <= CTRL_FLUSH;
    end else if (flush) begin
      m_ctrl <= CTRL_FLUSH;
      s_ctrl <= CTRL_FLUSH;
    end else begin
      if (load_m) begin
        m_data <= in_data;
        m_ctrl <= in_ctrl;
      end else if (pop_s) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end
      if (load_s) begin
        s_data <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register with stall and flush.
// Ports: clk, rst (async active-low), flush, stall, in_valid/in_ready/in_data/in_ctrl
// upstream, out_valid/out_ready/out_data/out_ctrl downstream, occupancy (held entries).
// SKID=1 uses the 2-entry skid buffer; SKID=0 is a single register whose
// in_ready is combinational from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter logic [CTRL_W-1:0] CTRL_FLUSH = CTRL_W'(CTRL_BUBBLE),
  parameter bit SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  generate
    if (SKID) begin : g_skid
      pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_FLUSH(CTRL_FLUSH)) u_buf (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
      );
    end else begin : g_reg
      logic valid, run;
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
      // run keeps in_ready low until the first edge after reset release.
      assign in_ready  = run & !stall & (!valid | out_ready);
      assign out_valid = valid & !stall;
      assign out_data  = data;
      assign out_ctrl  = ctrl;
      assign occupancy = {1'b0, valid};
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          run   <= 1'b0;
          valid <= 1'b0;
          data  <= '0;
          ctrl  <= CTRL_FLUSH;
        end else begin
          run <= 1'b1;
          if (flush) begin
            valid <= 1'b0;
            ctrl  <= CTRL_FLUSH;
          end else if (!stall) begin
            if (in_valid && in_ready) begin
              valid <= 1'b1;
              data  <= in_data;
              ctrl  <= in_ctrl;
            end else if (out_valid && out_ready) begin
              valid <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload and a separate control vector with a per-entry valid bit.
- Handshake is valid/ready, with stall and flush.
- Optional 2-entry skid buffer registers the upstream ready and breaks the combinational ready path between stages.

Parameters:
- DATA_W, 32: payload width (pc, pc4, ALU result, operands, ...). Retained on flush.
- CTRL_W, 8: control vector width (rf_we, ram_we, npc_op, flag, ...). Forced to CTRL_FLUSH on flush.
- CTRL_FLUSH, 0: value loaded into every held ctrl entry on flush (bubble encoding).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: kill all held entries and any same-cycle input.
- stall, input, 1: freeze the stage; no transfer in or out.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept this cycle.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control.
- out_valid, output, 1: head entry valid to downstream.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: head payload.
- out_ctrl, output, CTRL_W: head control.
- occupancy, output, 2: held entries, 0..2; max 1 when SKID=0.

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, data 0, ctrl CTRL_FLUSH, occupancy 0. out_valid=0.
  - in_ready=0 while rst=0; in_ready=1 from the first clock edge after release.
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
- Latency: an accepted entry appears on out_* on the next rising edge. Entries leave in FIFO order.
- Priority: reset > flush > stall > normal.
- Flush, registered at the edge:
  - Clear all valid bits; load CTRL_FLUSH into every ctrl entry; keep data unchanged.
  - Discard a same-cycle input even if in_valid & in_ready; discard the out-transfer of that cycle.
  - occupancy becomes 0. The following cycle out_valid=0 and in_ready=1.
- Stall with flush=0:
  - out_valid is gated to 0 combinationally; in_ready=0 in SKID=0 mode.
  - All state is held; no transfer occurs.
  - In SKID=1 mode in_ready is unaffected and still reflects the registered skid-empty value.
    - A same-cycle in-transfer is buffered into the skid register.
    - If the skid register is already full, in_ready=0 that cycle.
- SKID=0:
  - in_ready = !stall & (!valid | out_ready), combinational.
  - Simultaneous in- and out-transfer replaces the entry with no bubble; full throughput.
- SKID=1 states (main M, skid S):
  - EMPTY (M=0,S=0): in-transfer -> ONE.
  - ONE (M=1,S=0), outcomes:
    - in and out transfer together: stay ONE; M gets the input.
    - out only: -> EMPTY.
    - in only (downstream blocked or stalled): -> FULL; input goes to S.
  - FULL (M=1,S=1): in_ready=0.
    - Out-transfer: M <- S, -> ONE.
  - in_ready is a register: 1 in EMPTY and ONE, 0 in FULL. No combinational path from out_ready to in_ready.
  - out_* always driven from M.
- Boundary cases:
  - Flush while FULL: -> EMPTY in one edge.
  - out_ready toggling every cycle keeps order with no loss or duplication.
  - in_valid with in_ready=0 holds no state; upstream must hold its data.
  - Reset asserted mid-transfer drops all entries immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - stage ctrl field widths/offsets (RF_WE, RF_WSEL, RAM_WE, RAM_RSEL, NPC_OP, NPC_SEL, FLAG);
  - per-stage CTRL_W/DATA_W constants;
  - CTRL_FLUSH bubble encoding.
- One sub-module is natural: pipe_skid_buf, the 2-entry storage plus registered-ready FSM.
  - It is instantiated under generate when SKID=1.
  - The SKID=0 path is inline.

Test Plan:
- Reset: hold rst=0 with in_valid=1 and in_ctrl=8'hFF.
  - Expected: out_valid=0, out_ctrl=8'h00, occupancy=0, in_ready=0.
  - After release: in_ready=1 at the first edge.
- Streaming (SKID=1, out_ready=1): data 1..8 on consecutive cycles.
  - Expected: out_data 1..8 one cycle later, no gaps, occupancy never exceeds 1.
- Backpressure: load 0xA then 0xB with out_ready=0.
  - Expected: occupancy=2, in_ready=0.
  - Raise out_ready: out 0xA, then 0xB, occupancy 2->1->0.
- Flush while FULL with in_valid=1, data 0xC on the flush cycle.
  - Expected: next cycle out_valid=0, ctrl=CTRL_FLUSH, occupancy=0; 0xC never appears.
- Stall (SKID=0) on a held entry 0x55 for 3 cycles with out_ready=1.
  - Expected: out_valid=0 and in_ready=0 throughout.
  - After stall drops: 0x55 is delivered exactly once.
- Flush and stall together with 0x77 held.
  - Expected: flush wins; entry cleared; no output of 0x77.
